// File: rtl/pe_conv_ctrl.sv
// Sequencer for one systolic PE running a 3-tap 1-D convolution row.
// Optional stall-cycle counter is built when PE_CTRL_STALL_CNT_EN is defined.
module pe_conv_ctrl #(
  parameter int unsigned N      = 8,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned PE_LAT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [LEN_W-1:0] row_len,
  input  logic [3*N-1:0]   w_in,
  input  logic             act_valid,
  input  logic [N-1:0]     act_data,
  output logic             act_ready,
  output logic [N-1:0]     pe_i0,
  output logic [N-1:0]     pe_i1,
  output logic [N-1:0]     pe_w0,
  output logic [N-1:0]     pe_w1,
  output logic [N-1:0]     pe_w2,
  output logic             pe_sel_m0,
  output logic             pe_sel_m1,
  output logic             pe_sel_m2,
  output logic             pe_sel_m3,
  output logic             pe_sel0,
  output logic             pe_sel1,
  output logic             pe_ce,
  output logic             pe_clr_n,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic [15:0]      stall_cnt
);

  localparam int unsigned SEL_W = 6;
  localparam logic [SEL_W-1:0] SEL_FILL = 6'b110100; // {m3,m2,m1,m0,sel1,sel0}
  localparam logic [SEL_W-1:0] SEL_RUN  = 6'b001010;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FILL, S_RUN, S_DRAIN, S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [LEN_W-1:0]   cnt, cnt_nxt;
  logic [LEN_W-1:0]   len_q;
  logic [3*N-1:0]     w_q;
  logic [N-1:0]       i0_q, i1_q;
  logic [PE_LAT-1:0]  tok;
  logic [SEL_W-1:0]   sel_q, sel_nxt;
  logic               ready_nxt, busy_nxt, done_nxt, clr_n_nxt;
  logic               xfer, run_xfer;

  // act_ready is a flop that is high exactly in FILL/RUN
  assign xfer     = act_ready & act_valid;
  assign run_xfer = xfer & (state == S_RUN);

  // Next-state, counter and registered-output decode
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = '0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD: begin
        cnt_nxt   = '0;
        state_nxt = (len_q >= LEN_W'(3)) ? S_FILL : S_DONE;
      end
      S_FILL: if (xfer) begin
        if (cnt == LEN_W'(1)) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + LEN_W'(1);
        end
      end
      S_RUN: if (xfer) begin
        if (cnt == len_q - LEN_W'(3)) begin
          state_nxt = S_DRAIN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + LEN_W'(1);
        end
      end
      S_DRAIN: begin
        if (cnt == LEN_W'(PE_LAT - 1)) begin
          state_nxt = S_DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + LEN_W'(1);
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    ready_nxt = (state_nxt == S_FILL) || (state_nxt == S_RUN);
    busy_nxt  = (state_nxt != S_IDLE);
    done_nxt  = (state_nxt == S_DONE);
    clr_n_nxt = (state_nxt != S_LOAD);
    if (state_nxt == S_FILL)     sel_nxt = SEL_FILL;
    else if (state_nxt == S_RUN) sel_nxt = SEL_RUN;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      act_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pe_clr_n  <= 1'b1;
      sel_q     <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      act_ready <= ready_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      pe_clr_n  <= clr_n_nxt;
      sel_q     <= sel_nxt;
    end
  end

  // Row config, activation history and out_valid token pipeline
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q <= '0;
      w_q   <= '0;
      i0_q  <= '0;
      i1_q  <= '0;
      tok   <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        len_q <= row_len;
        w_q   <= w_in;
      end
      if (state == S_LOAD) begin
        i0_q <= '0;
        i1_q <= '0;
      end else if (xfer) begin
        i0_q <= i1_q;
        i1_q <= act_data;
      end
      if (pe_ce) tok <= (tok << 1) | PE_LAT'(run_xfer);
    end
  end

  // PE data and enable must follow act_valid in the same cycle, so they
  // are decoded from the state flops plus the handshake; stalls replay the held pair.
  assign pe_ce = (state == S_LOAD) || (state == S_DRAIN) || xfer;
  assign pe_i0 = act_ready ? (act_valid ? i1_q : i0_q) : '0;
  assign pe_i1 = act_ready ? (act_valid ? act_data : i1_q) : '0;

  assign out_valid = tok[PE_LAT-1];
  assign {pe_w2, pe_w1, pe_w0} = w_q;
  assign {pe_sel_m3, pe_sel_m2, pe_sel_m1, pe_sel_m0, pe_sel1, pe_sel0} = sel_q;

`ifdef PE_CTRL_STALL_CNT_EN
  logic [15:0] stall_q;

  // Saturating count of FILL/RUN cycles without a valid activation
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else if (state == S_LOAD) begin
      stall_q <= '0;
    end else if (act_ready && !act_valid && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pe_conv_ctrl.sv
// Directed self-checking bench for pe_conv_ctrl; cycle 0 is the cycle start is high.
module tb_pe_conv_ctrl;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [7:0]  row_len;
  logic [23:0] w_in;
  logic        act_valid;
  logic [7:0]  act_data;
  logic        act_ready;
  logic [7:0]  pe_i0, pe_i1, pe_w0, pe_w1, pe_w2;
  logic        pe_sel_m0, pe_sel_m1, pe_sel_m2, pe_sel_m3, pe_sel0, pe_sel1;
  logic        pe_ce, pe_clr_n, out_valid, busy, done;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

`ifdef PE_CTRL_STALL_CNT_EN
  localparam logic [15:0] STALL_EXP = 16'd2;
`else
  localparam logic [15:0] STALL_EXP = 16'd0;
`endif
  localparam logic [23:0] W321 = 24'h030201;

  logic [299:0] ready_l, ov_l, done_l, busy_l, ce_l, clr_l;
  logic [7:0]   i0_l [0:299];
  logic [7:0]   i1_l [0:299];
  logic [5:0]   sel_l [0:299];
  logic [23:0]  w_l [0:299];

  pe_conv_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .row_len(row_len), .w_in(w_in),
    .act_valid(act_valid), .act_data(act_data), .act_ready(act_ready),
    .pe_i0(pe_i0), .pe_i1(pe_i1), .pe_w0(pe_w0), .pe_w1(pe_w1), .pe_w2(pe_w2),
    .pe_sel_m0(pe_sel_m0), .pe_sel_m1(pe_sel_m1), .pe_sel_m2(pe_sel_m2),
    .pe_sel_m3(pe_sel_m3), .pe_sel0(pe_sel0), .pe_sel1(pe_sel1),
    .pe_ce(pe_ce), .pe_clr_n(pe_clr_n), .out_valid(out_valid), .busy(busy),
    .done(done), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one row from an IDLE cycle and log every output per cycle
  task automatic run_row(input logic [7:0] len, input logic [23:0] w, input int stall_lo,
                         input int stall_hi, input int ign_cyc, input int ncyc);
    int idx;
    idx = 0;
    ready_l = '0; ov_l = '0; done_l = '0; busy_l = '0; ce_l = '0; clr_l = '0;
    for (int c = 0; c < ncyc; c++) begin
      start     = (c == 0) || (c == ign_cyc);
      row_len   = (c == ign_cyc) ? 8'd2 : len;
      w_in      = (c == ign_cyc) ? 24'hFFFFFF : w;
      act_valid = !(c >= stall_lo && c <= stall_hi);
      act_data  = act_valid ? 8'(idx + 1) : 8'hAA;
      @(negedge clk);
      ready_l[c] = act_ready;
      ov_l[c]    = out_valid;
      done_l[c]  = done;
      busy_l[c]  = busy;
      ce_l[c]    = pe_ce;
      clr_l[c]   = pe_clr_n;
      i0_l[c]    = pe_i0;
      i1_l[c]    = pe_i1;
      sel_l[c]   = {pe_sel_m3, pe_sel_m2, pe_sel_m1, pe_sel_m0, pe_sel1, pe_sel0};
      w_l[c]     = {pe_w2, pe_w1, pe_w0};
      if (act_valid && act_ready) idx++;
      @(posedge clk);
      #1;
    end
    start     = 1'b0;
    act_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({act_ready, busy, done, out_valid, pe_ce, pe_clr_n} !== 6'b000001) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000001",
               {act_ready, busy, done, out_valid, pe_ce, pe_clr_n});
    end
    checks++;
    if ({pe_i0, pe_i1, pe_w0, pe_w1, pe_w2} !== 40'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", {pe_i0, pe_i1, pe_w0, pe_w1, pe_w2});
    end
    checks++;
    if ({pe_sel_m3, pe_sel_m2, pe_sel_m1, pe_sel_m0, pe_sel1, pe_sel0, stall_cnt} !== 22'h0) begin
      errors++;
      $display("FAIL reset_sel_stall: got %h expected 0",
               {pe_sel_m3, pe_sel_m2, pe_sel_m1, pe_sel_m0, pe_sel1, pe_sel0, stall_cnt});
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_nominal;
    logic [7:0] exp_i1 [0:5];
    logic [7:0] exp_i0 [0:5];
    exp_i1 = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0};
    exp_i0 = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd0};
    run_row(8'd5, W321, -1, -1, -1, 16);
    checks++;
    if (ready_l[15:0] !== 16'h007C) begin
      errors++; $display("FAIL nom_ready: got %h expected 007c", ready_l[15:0]);
    end
    checks++;
    if (ov_l[15:0] !== 16'h0700) begin
      errors++; $display("FAIL nom_out_valid: got %h expected 0700", ov_l[15:0]);
    end
    checks++;
    if (done_l[15:0] !== 16'h0800) begin
      errors++; $display("FAIL nom_done: got %h expected 0800", done_l[15:0]);
    end
    checks++;
    if (busy_l[15:0] !== 16'h0FFE) begin
      errors++; $display("FAIL nom_busy: got %h expected 0ffe", busy_l[15:0]);
    end
    checks++;
    if (ce_l[15:0] !== 16'h07FE) begin
      errors++; $display("FAIL nom_ce: got %h expected 07fe", ce_l[15:0]);
    end
    checks++;
    if (clr_l[15:0] !== 16'hFFFD) begin
      errors++; $display("FAIL nom_clr_n: got %h expected fffd", clr_l[15:0]);
    end
    checks++;
    if (w_l[1] !== W321 || w_l[15] !== W321) begin
      errors++; $display("FAIL nom_weights: got %h/%h expected %h", w_l[1], w_l[15], W321);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if ({i1_l[k+2], i0_l[k+2]} !== {exp_i1[k], exp_i0[k]}) begin
        errors++;
        $display("FAIL nom_data c%0d: got %h expected %h", k + 2,
                 {i1_l[k+2], i0_l[k+2]}, {exp_i1[k], exp_i0[k]});
      end
    end
    checks++;
    if ({sel_l[1], sel_l[2], sel_l[3], sel_l[4], sel_l[6], sel_l[7]} !==
        {6'b000000, 6'b110100, 6'b110100, 6'b001010, 6'b001010, 6'b000000}) begin
      errors++;
      $display("FAIL nom_sel: got %b %b %b %b %b %b", sel_l[1], sel_l[2], sel_l[3],
               sel_l[4], sel_l[6], sel_l[7]);
    end
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++; $display("FAIL nom_stall_cnt: got %0d expected 0", stall_cnt);
    end
  endtask

  task automatic test_stall;
    run_row(8'd5, W321, 4, 5, -1, 16);
    checks++;
    if (ready_l[15:0] !== 16'h01FC) begin
      errors++; $display("FAIL stall_ready: got %h expected 01fc", ready_l[15:0]);
    end
    checks++;
    if (ov_l[15:0] !== 16'h1C00) begin
      errors++; $display("FAIL stall_out_valid: got %h expected 1c00", ov_l[15:0]);
    end
    checks++;
    if (done_l[15:0] !== 16'h2000 || busy_l[15:0] !== 16'h3FFE) begin
      errors++;
      $display("FAIL stall_done_busy: got %h/%h expected 2000/3ffe", done_l[15:0], busy_l[15:0]);
    end
    checks++;
    if (ce_l[15:0] !== 16'h1FCE) begin
      errors++; $display("FAIL stall_ce: got %h expected 1fce", ce_l[15:0]);
    end
    checks++;
    if ({i1_l[4], i0_l[4], i1_l[5], i0_l[5], i1_l[6], i0_l[6]} !== 48'h0201_0201_0302) begin
      errors++;
      $display("FAIL stall_hold: got %h expected 020102010302",
               {i1_l[4], i0_l[4], i1_l[5], i0_l[5], i1_l[6], i0_l[6]});
    end
    checks++;
    if (stall_cnt !== STALL_EXP) begin
      errors++; $display("FAIL stall_cnt: got %0d expected %0d", stall_cnt, STALL_EXP);
    end
  endtask

  task automatic test_short;
    run_row(8'd2, 24'h0A0B0C, -1, -1, -1, 6);
    checks++;
    if (done_l[5:0] !== 6'b000100 || busy_l[5:0] !== 6'b000110) begin
      errors++;
      $display("FAIL short2_done_busy: got %b/%b expected 000100/000110", done_l[5:0], busy_l[5:0]);
    end
    checks++;
    if (ready_l[5:0] !== 6'b0 || ov_l[5:0] !== 6'b0 || ce_l[5:0] !== 6'b000010) begin
      errors++;
      $display("FAIL short2_ready_ov_ce: got %b/%b/%b expected 0/0/000010",
               ready_l[5:0], ov_l[5:0], ce_l[5:0]);
    end
    checks++;
    if (w_l[2] !== 24'h0A0B0C) begin
      errors++; $display("FAIL short2_weights: got %h expected 0a0b0c", w_l[2]);
    end
    run_row(8'd0, W321, -1, -1, -1, 6);
    checks++;
    if (done_l[5:0] !== 6'b000100 || ready_l[5:0] !== 6'b0 || ov_l[5:0] !== 6'b0) begin
      errors++;
      $display("FAIL short0: got done %b ready %b ov %b expected 000100/0/0",
               done_l[5:0], ready_l[5:0], ov_l[5:0]);
    end
  endtask

  task automatic test_start_ignored;
    run_row(8'd5, W321, -1, -1, 4, 16);
    checks++;
    if (done_l[15:0] !== 16'h0800 || ov_l[15:0] !== 16'h0700) begin
      errors++;
      $display("FAIL ign_start: got done %h ov %h expected 0800/0700", done_l[15:0], ov_l[15:0]);
    end
    checks++;
    if (w_l[7] !== W321) begin
      errors++; $display("FAIL ign_start_weights: got %h expected %h", w_l[7], W321);
    end
  endtask

  task automatic test_reset_mid_row;
    logic seen;
    for (int c = 0; c < 6; c++) begin
      start     = (c == 0);
      row_len   = 8'd5;
      w_in      = W321;
      act_valid = 1'b1;
      act_data  = 8'(c + 16);
      @(negedge clk);
      if (c < 5) begin
        @(posedge clk);
        #1;
      end
    end
    checks++;
    if ({busy, act_ready, pe_ce} !== 3'b111) begin
      errors++; $display("FAIL midrow_in_run: got %b expected 111", {busy, act_ready, pe_ce});
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({act_ready, busy, done, out_valid, pe_ce, pe_clr_n} !== 6'b000001 ||
        {pe_i0, pe_i1, pe_w0, pe_w1, pe_w2} !== 40'h0 ||
        {pe_sel_m3, pe_sel_m2, pe_sel_m1, pe_sel_m0, pe_sel1, pe_sel0} !== 6'b0) begin
      errors++;
      $display("FAIL midrow_async_reset: got ctrl %b data %h", {act_ready, busy, done,
               out_valid, pe_ce, pe_clr_n}, {pe_i0, pe_i1, pe_w0, pe_w1, pe_w2});
    end
    act_valid = 1'b0;
    start     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      seen = seen | done | out_valid | busy;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL midrow_no_done: got %b expected 0", seen);
    end
    @(posedge clk);
    #1;
    run_row(8'd5, W321, -1, -1, -1, 16);
    checks++;
    if (done_l[15:0] !== 16'h0800 || ov_l[15:0] !== 16'h0700 || ready_l[15:0] !== 16'h007C) begin
      errors++;
      $display("FAIL midrow_restart: got done %h ov %h ready %h", done_l[15:0], ov_l[15:0],
               ready_l[15:0]);
    end
  endtask

  task automatic test_long;
    int done_at;
    run_row(8'd255, W321, -1, -1, -1, 264);
    done_at = -1;
    for (int c = 263; c >= 0; c--) if (done_l[c]) done_at = c;
    checks++;
    if ($countones(ov_l) !== 253) begin
      errors++; $display("FAIL long_out_valid: got %0d expected 253", $countones(ov_l));
    end
    checks++;
    if (done_at !== 261 || $countones(done_l) !== 1) begin
      errors++;
      $display("FAIL long_done: got cycle %0d count %0d expected 261/1", done_at, $countones(done_l));
    end
    checks++;
    if ($countones(busy_l) !== 261 || $countones(ready_l) !== 255) begin
      errors++;
      $display("FAIL long_busy_ready: got %0d/%0d expected 261/255",
               $countones(busy_l), $countones(ready_l));
    end
    checks++;
    if (i1_l[256] !== 8'd255 || i0_l[256] !== 8'd254) begin
      errors++; $display("FAIL long_last_data: got %0d/%0d expected 255/254", i1_l[256], i0_l[256]);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    row_len   = '0;
    w_in      = '0;
    act_valid = 1'b0;
    act_data  = '0;
    repeat (2) @(posedge clk);
    test_reset;
    test_nominal;
    test_stall;
    test_short;
    test_start_ignored;
    test_reset_mid_row;
    test_long;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_conv_ctrl.md
# pe_conv_ctrl

Sequencer for one systolic-array PE running a 3-tap 1-D convolution row. It latches three weights and accepts a row of activations over a valid/ready stream. It drives the PE data inputs, mux selects, clock-enable and PSUM clear, and flags which PE output cycles carry valid convolution results. It sits between the activation/weight buffers and a single PE instance; one controller per PE column.

## Interface
- N, 8, activation/weight width
- LEN_W, 8, width of row-length field
- PE_LAT, 4, PE input-to-output latency in enabled cycles

- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin a row; sampled only in IDLE
- row_len  in  LEN_W  activations in the row; sampled with start
- w_in  in  3N  packed weights {w2,w1,w0}; sampled with start
- act_valid  in  1  activation available
- act_data  in  N  activation value
- act_ready  out  1  controller accepts activation this cycle
- pe_i0, pe_i1  out  N each  PE data inputs
- pe_w0, pe_w1, pe_w2  out  N each  PE weights
- pe_sel_m0..pe_sel_m3  out  1 each  PE 2:1 mux selects
- pe_sel0, pe_sel1  out  1 each  PE 3:1 mux select
- pe_ce  out  1  PE clock enable
- pe_clr_n  out  1  PE PSUM clear, active-low
- out_valid  out  1  PE output this cycle is a valid result
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at row completion
- stall_cnt  out  16  stall-cycle count (see Configuration)

## Operation
- States: IDLE, LOAD, FILL, RUN, DRAIN, DONE.
- IDLE:
  - On start, latch row_len and w_in, then go to LOAD.
  - start while not in IDLE is ignored.
- LOAD (1 cycle):
  - Weights appear on pe_w0..2; they hold until the next LOAD.
  - pe_clr_n=0 and pe_ce=1.
  - Next state: FILL if row_len≥3, else DONE. No activations are consumed when row_len<3.
- FILL: accept 2 activations, then go to RUN.
- RUN: accept row_len−2 activations, then go to DRAIN.
- Data path on each accepted activation:
  - pe_i1 = act_data.
  - pe_i0 = the previous accepted activation (0 for the first).
- Handshake:
  - act_ready=1 in FILL and RUN only.
  - A transfer occurs when act_valid && act_ready.
  - In FILL/RUN with act_valid=0 (stall): pe_ce=0, all PE drives hold, and the token pipeline holds.
- Select drives:
  - FILL: m0=1, m1=0, m2=1, m3=1, {sel1,sel0}=00.
  - RUN: m0=0, m1=1, m2=0, m3=0, {sel1,sel0}=10.
  - All other states: all selects 0.
- DRAIN: pe_ce=1, pe_i0=pe_i1=0, for exactly PE_LAT cycles, then go to DONE.
- DONE (1 cycle): done=1, then go to IDLE.
- out_valid tracking:
  - A PE_LAT-deep token shift register, advancing only when pe_ce=1, carries one token per RUN transfer.
  - out_valid is the token at the output end.
  - Exactly row_len−2 out_valid pulses occur per row.
- Counters use LEN_W bits. row_len=0 is treated as <3. row_len=2^LEN_W−1 must not wrap.

## Timing
- Reset values:
  - State: IDLE.
  - All outputs 0, except pe_clr_n=1.
  - Weight, history and token registers: 0.
- Assertion of reset_n=0 mid-row:
  - Immediately forces the reset values.
  - Discards pending tokens.
  - Produces no done pulse.
- Start-to-first-accept: start at cycle 0 → LOAD cycle 1 → first act_ready cycle 2.
- A RUN transfer in cycle t produces out_valid in cycle t+PE_LAT, provided no stall occurs in between. Each stall cycle adds 1.
- With no stalls, done is asserted at cycle row_len+PE_LAT+2 after start.
- act_ready is registered from state only; it does not depend combinationally on act_valid.

## Configuration
- PE_CTRL_STALL_CNT_EN defined:
  - stall_cnt increments on each FILL/RUN cycle with act_valid=0.
  - It saturates at 0xFFFF and clears in LOAD.
- PE_CTRL_STALL_CNT_EN undefined: stall_cnt is tied to 0 and no counter register exists.

## Test plan
- row_len=5, w={3,2,1}, activations 1..5 with no stalls:
  - act_ready at cycles 2–6.
  - out_valid at cycles 8, 9, 10.
  - done at cycle 11; busy cycles 1–11.
- Same row with act_valid low at cycles 4–5:
  - pe_ce=0 and PE drives hold for those 2 cycles.
  - out_valid moves to cycles 10, 11, 12; done at cycle 13.
  - stall_cnt=2 when the macro is defined, 0 when undefined.
- row_len=2: LOAD then DONE (done at cycle 2), act_ready never asserts, no out_valid.
- start asserted during RUN: ignored. Then reset_n pulsed low in RUN: all outputs return to their reset values asynchronously, no done pulse, and the next start is accepted normally.
- row_len=255, continuous valid: exactly 253 out_valid pulses, no counter wrap, done at cycle 261.
